minmax_tracker: RTL and testbench
=================================

MINMAX_TRACKER -- requirements
Module: minmax_tracker

Interface
REQ-001 SHALL provide parameter word_size, default 16, giving the sample width in bits.
REQ-002 SHALL provide parameter cnt_width, default 8, giving the sample-count width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream sample is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-007 SHALL have port in_data, input, word_size bits: unsigned sample.
REQ-008 SHALL have port in_last, input, 1 bit: the sample closes the current frame.
REQ-009 SHALL have port out_valid, output, 1 bit: the frame result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port out_min, output, word_size bits: smallest sample in the frame.
REQ-012 SHALL have port out_max, output, word_size bits: largest sample in the frame.
REQ-013 SHALL have port out_count, output, cnt_width bits: number of samples in the frame, saturating.
REQ-014 SHALL have port out_sat, output, 1 bit: out_count saturated during the frame.

Function
REQ-015 SHALL accept a sample only when in_valid and in_ready are both 1 in the same cycle.
REQ-016 SHALL implement a three-state FSM. IDLE: no sample held. ACCUM: frame open. HOLD: result presented.
REQ-017 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD.
REQ-018 IDLE, on an accepted sample, SHALL load min=max=in_data and count=1, then go to HOLD if in_last=1, otherwise to ACCUM.
REQ-019 ACCUM, on an accepted sample, SHALL compare unsigned: if in_data<min, min<=in_data; if in_data>max, max<=in_data; if equal, leave min/max unchanged.
REQ-020 ACCUM SHALL increment count on each accepted sample; at 2^cnt_width-1 count SHALL hold and the sat flag SHALL set and remain set for the frame.
REQ-021 ACCUM, on an accepted sample with in_last=1, SHALL include that sample, then go to HOLD.
REQ-022 A cycle without an accepted sample SHALL leave all state unchanged, including in_valid=1 with in_ready=0.
REQ-023 SHALL assert out_valid exactly when in HOLD; latency is 1 clock from the accepted last sample to out_valid=1.
REQ-024 While out_valid=1, out_min, out_max, out_count and out_sat SHALL stay stable until the handshake.
REQ-025 HOLD, on out_ready=1, SHALL go to IDLE next cycle and clear the sat flag; a new sample is accepted no earlier than that next cycle.
REQ-026 A single-sample frame (in_last on the first sample) SHALL yield min=max=sample and count=1.
REQ-027 Outside HOLD, out_min, out_max, out_count and out_sat SHALL show the current registered values; they are meaningful only when out_valid=1.

Reset
REQ-028 With rst=1 at a clock edge, the FSM SHALL go to IDLE, with min=0, max=0, count=0, sat=0, out_valid=0 and in_ready=1 on the following cycle.
REQ-029 rst SHALL take priority over every handshake in the same cycle.
REQ-030 Reset SHALL discard a partial frame in ACCUM or an unconsumed result in HOLD, with no output produced.

Verification
REQ-031 Frame 5,2,9,9,1(last) with out_ready=1 -> one cycle later out_valid=1, min=1, max=9, count=5, sat=0; IDLE the following cycle.
REQ-032 Single sample 0xFFFF with last=1 -> out_valid=1, min=max=0xFFFF, count=1.
REQ-033 Result held with out_ready=0 for 4 cycles while in_valid=1 -> in_ready=0 throughout, outputs stable, no sample absorbed; out_ready=1 -> IDLE.
REQ-034 With cnt_width=3, a frame of 10 samples -> count=7, sat=1; the next frame of 2 samples -> count=2, sat=0.
REQ-035 Frame 3,7 in progress, then rst for 1 cycle, then frame 4(last) -> only one result: min=max=4, count=1.
REQ-036 in_valid toggling 1,0,1,0 across frame 8,6(last) -> count=2, min=6, max=8; idle cycles have no effect.

Source files
------------

// File: rtl/minmax_tracker.sv
// minmax_tracker: per-frame unsigned min/max and saturating sample count behind valid/ready handshakes
module minmax_tracker #(
  parameter int word_size = 16,
  parameter int cnt_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [word_size-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [word_size-1:0] out_min,
  output logic [word_size-1:0] out_max,
  output logic [cnt_width-1:0] out_count,
  output logic                 out_sat
);
  localparam logic [1:0] idle = 2'd0;
  localparam logic [1:0] accum = 2'd1;
  localparam logic [1:0] hold = 2'd2;
  localparam logic [cnt_width-1:0] cnt_max = '1;
  logic [1:0] state_q, state_d;
  logic [word_size-1:0] min_q, min_d, max_q, max_d;
  logic [cnt_width-1:0] count_q, count_d;
  logic sat_q, sat_d;
  logic take;
  assign in_ready = state_q != hold;
  assign take = in_valid && in_ready;
  assign out_valid = state_q == hold;
  assign out_min = min_q;
  assign out_max = max_q;
  assign out_count = count_q;
  assign out_sat = sat_q;
  always_comb begin
    state_d = state_q;
    min_d = min_q;
    max_d = max_q;
    count_d = count_q;
    sat_d = sat_q;
    if (state_q == idle && take) begin
      min_d = in_data;
      max_d = in_data;
      count_d = cnt_width'(1);
      sat_d = 1'b0;
      state_d = in_last ? hold : accum;
    end else if (state_q == accum && take) begin
      min_d = in_data < min_q ? in_data : min_q;
      max_d = in_data > max_q ? in_data : max_q;
      count_d = count_q == cnt_max ? count_q : count_q + cnt_width'(1);
      sat_d = sat_q || count_q == cnt_max;
      state_d = in_last ? hold : accum;
    end else if (state_q == hold && out_ready) begin
      sat_d = 1'b0;
      state_d = idle;
    end else if (state_q == 2'd3) begin
      state_d = idle;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= idle;
      min_q <= '0;
      max_q <= '0;
      count_q <= '0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q <= min_d;
      max_q <= max_d;
      count_q <= count_d;
      sat_q <= sat_d;
    end
  end
endmodule

// File: tb/tb_minmax_tracker.sv
// tb_minmax_tracker: directed and randomized frames checked against a queue-based min/max/count model
module tb_minmax_tracker;
  localparam int w = 16;
  localparam int cw = 3;
  localparam int cmax = (1 << cw) - 1;
  typedef logic [w-1:0] word_q_t[$];
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic [w-1:0] in_data = '0;
  logic in_ready, out_valid, out_sat;
  logic [w-1:0] out_min, out_max;
  logic [cw-1:0] out_count;
  int n_checks = 0, n_errors = 0;
  always #5 clk = ~clk;
  minmax_tracker #(.word_size(w), .cnt_width(cw)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min),
    .out_max(out_max), .out_count(out_count), .out_sat(out_sat)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 0;
      in_data = w'($urandom);
      in_last = 1'($urandom);
      tick();
    end
    in_last = 0;
  endtask
  // gap < 0 picks 0..2 idle cycles before each sample at random
  task automatic frame(input word_q_t s, input int gap, input int hold_cycles);
    int mn, mx, n;
    mn = int'(s[0]);
    mx = int'(s[0]);
    foreach (s[i]) begin
      if (int'(s[i]) < mn) mn = int'(s[i]);
      if (int'(s[i]) > mx) mx = int'(s[i]);
    end
    n = s.size();
    foreach (s[i]) begin
      idle_cycles(gap < 0 ? $urandom_range(2, 0) : gap);
      check("in_ready_open", 32'(in_ready), 1);
      check("out_valid_open", 32'(out_valid), 0);
      in_valid = 1;
      in_data = s[i];
      in_last = (i == n - 1);
      tick();
    end
    in_valid = 0;
    in_last = 0;
    check("out_valid", 32'(out_valid), 1);
    check("in_ready_hold", 32'(in_ready), 0);
    check("min", 32'(out_min), mn);
    check("max", 32'(out_max), mx);
    check("count", 32'(out_count), n > cmax ? cmax : n);
    check("sat", 32'(out_sat), n > cmax);
    for (int k = 0; k < hold_cycles; k++) begin
      in_valid = 1;
      in_data = w'($urandom);
      in_last = 1'($urandom);
      tick();
      check("hold_in_ready", 32'(in_ready), 0);
      check("hold_valid", 32'(out_valid), 1);
      check("hold_min", 32'(out_min), mn);
      check("hold_max", 32'(out_max), mx);
      check("hold_count", 32'(out_count), n > cmax ? cmax : n);
    end
    in_valid = 0;
    in_last = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    check("released_valid", 32'(out_valid), 0);
    check("released_ready", 32'(in_ready), 1);
    check("released_sat", 32'(out_sat), 0);
  endtask
  initial begin
    word_q_t q;
    int len;
    rst = 1;
    tick();
    tick();
    rst = 0;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_min", 32'(out_min), 0);
    check("rst_max", 32'(out_max), 0);
    check("rst_count", 32'(out_count), 0);
    check("rst_sat", 32'(out_sat), 0);
    q = {16'd5, 16'd2, 16'd9, 16'd9, 16'd1};
    frame(q, 0, 0);
    q = {16'hFFFF};
    frame(q, 0, 0);
    q = {16'd10, 16'd20};
    frame(q, 0, 4);
    q = {};
    for (int i = 0; i < 10; i++) q.push_back(w'($urandom));
    frame(q, 0, 1);
    q = {16'd300, 16'd40};
    frame(q, 0, 0);
    q = {16'd8, 16'd6};
    frame(q, 1, 0);
    in_valid = 1;
    in_data = 3;
    tick();
    in_data = 7;
    tick();
    rst = 1;
    in_data = 5;
    in_last = 1;
    tick();
    rst = 0;
    in_valid = 0;
    in_last = 0;
    check("rst_accum_valid", 32'(out_valid), 0);
    check("rst_accum_count", 32'(out_count), 0);
    check("rst_accum_ready", 32'(in_ready), 1);
    q = {16'd4};
    frame(q, 0, 0);
    in_valid = 1;
    in_data = 16'h55;
    in_last = 1;
    tick();
    in_valid = 0;
    in_last = 0;
    check("pre_rst_hold", 32'(out_valid), 1);
    rst = 1;
    out_ready = 1;
    tick();
    rst = 0;
    out_ready = 0;
    check("rst_hold_valid", 32'(out_valid), 0);
    check("rst_hold_count", 32'(out_count), 0);
    check("rst_hold_max", 32'(out_max), 0);
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(12, 1);
      if (len == cmax) len = cmax + 1;
      q = {};
      for (int i = 0; i < len; i++)
        q.push_back($urandom_range(1, 0) ? w'($urandom_range(3, 0)) : w'($urandom));
      frame(q, -1, $urandom_range(3, 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
